// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised 1RW+1R synchronous SRAM with write masks, bypass, read latency and clear sweep
module sram_1rw1r_param #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 9,
   parameter int                    NUM_WMASKS     = 4,
   parameter int                    READ_LATENCY   = 1,
   parameter bit                    BYPASS         = 1'b1,
   parameter bit                    CLEAR_ON_RESET = 1'b0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_busy,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic                  rvalid0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  rvalid1
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int LANE = DATA_WIDTH / NUM_WMASKS;
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $fatal(1, "READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_mask
      $fatal(1, "DATA_WIDTH must be a multiple of NUM_WMASKS");
   end

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  act, wr0, rd0, rd1, wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data, old0, merged, rdata1;
   logic                  s0_v_q, s0_v_d, s1_v_q, s1_v_d;
   logic [DATA_WIDTH-1:0] s0_d_q, s0_d_d, s1_d_q, s1_d_d;
   logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;

   assign init_busy = state_q == CLEAR;
   assign dout0 = dout0_q;
   assign dout1 = dout1_q;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;

   // Sweep next state: CLEAR walks 0..DEPTH-1 one word per cycle, leaving after the last word
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         state_d = cnt_q == LAST ? IDLE : CLEAR;
      end
   end

   // Request decode and masked merge; nothing is accepted in reset or while sweeping
   always_comb begin
      act = !rst && state_q == IDLE;
      wr0 = act && !csb0 && !web0;
      rd0 = act && !csb0 && web0;
      rd1 = act && !csb1;
      old0 = mem[addr0];
      merged = old0;
      for (int i = 0; i < NUM_WMASKS; i++)
         if (wmask0[i]) merged[i*LANE +: LANE] = din0[i*LANE +: LANE];
      wr_en = !rst && (init_busy || wr0);
      wr_addr = init_busy ? cnt_q[ADDR_WIDTH-1:0] : addr0;
      wr_data = init_busy ? INIT_VALUE : merged;
      rdata1 = (BYPASS && wr0 && addr1 == addr0) ? merged : mem[addr1];
   end

   // Read pipeline: latency 1 loads the outputs directly, latency 2 goes through one stage
   always_comb begin
      s0_v_d = rd0;
      s0_d_d = old0;
      s1_v_d = rd1;
      s1_d_d = rdata1;
      rvalid0_d = READ_LATENCY == 1 ? rd0 : s0_v_q;
      rvalid1_d = READ_LATENCY == 1 ? rd1 : s1_v_q;
      dout0_d = READ_LATENCY == 1 ? (rd0 ? old0 : dout0_q) : (s0_v_q ? s0_d_q : dout0_q);
      dout1_d = READ_LATENCY == 1 ? (rd1 ? rdata1 : dout1_q) : (s1_v_q ? s1_d_q : dout1_q);
   end

   // Storage array: not reset, one word written per cycle by either the sweep or port 0
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // State, pipeline and output registers
   always_ff @(posedge clk) begin
      s0_d_q <= s0_d_d;
      s1_d_q <= s1_d_d;
      if (rst) begin
         state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
         cnt_q <= '0;
         s0_v_q <= 1'b0;
         s1_v_q <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         dout0_q <= '0;
         dout1_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         s0_v_q <= s0_v_d;
         s1_v_q <= s1_v_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         dout0_q <= dout0_d;
         dout1_q <= dout1_d;
      end
   end
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb_sram_1rw1r_param: directed checks of two shared-stimulus instances (latency 1 with bypass, latency 2 without)
module tb_sram_1rw1r_param;
   logic        clk = 1'b0;
   logic        rst, csb0, web0, csb1;
   logic [3:0]  wmask0;
   logic [8:0]  addr0, addr1;
   logic [31:0] din0;
   logic        busy_a, v0_a, v1_a, busy_b, v0_b, v1_b;
   logic [31:0] d0_a, d1_a, d0_b, d1_b;
   int          vecs = 0, errs = 0, n, leak;

   sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_WMASKS(4), .READ_LATENCY(1), .BYPASS(1'b1),
      .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'hDEADBEEF)) dut_a (
      .clk(clk), .rst(rst), .init_busy(busy_a), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
      .din0(din0), .dout0(d0_a), .rvalid0(v0_a), .csb1(csb1), .addr1(addr1), .dout1(d1_a), .rvalid1(v1_a));

   sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_WMASKS(4), .READ_LATENCY(2), .BYPASS(1'b0),
      .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'hDEADBEEF)) dut_b (
      .clk(clk), .rst(rst), .init_busy(busy_b), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
      .din0(din0), .dout0(d0_b), .rvalid0(v0_b), .csb1(csb1), .addr1(addr1), .dout1(d1_b), .rvalid1(v1_b));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic count_sweep;
      n = 0;
      while (busy_a && n < 600) begin
         tick;
         n++;
         leak += int'(v0_a | v1_a | v0_b | v1_b);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = '0; din0 = '0; csb1 = 1'b1; addr1 = '0;
      leak = 0;
      tick;
      tick;
      chk("rst_d0_a", d0_a, 0);
      chk("rst_v0_a", v0_a, 0);
      chk("rst_d1_a", d1_a, 0);
      chk("rst_v1_a", v1_a, 0);
      chk("rst_d1_b", d1_b, 0);
      chk("rst_v0_b", v0_b, 0);
      chk("rst_busy_a", busy_a, 1);
      chk("rst_busy_b", busy_b, 1);
      rst = 1'b0;
      count_sweep;
      chk("sweep_len", n, 512);
      chk("sweep_busy_b", busy_b, 0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      repeat (100) tick;
      chk("busy_at_100", busy_a, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd3; din0 = 32'h55555555; csb1 = 1'b0; addr1 = 9'd3;
      leak = 0;
      count_sweep;
      chk("restart_len", n, 512);
      csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
      tick;
      leak += int'(v0_a | v1_a | v0_b | v1_b);
      tick;
      leak += int'(v0_a | v1_a | v0_b | v1_b);
      chk("clear_no_rvalid", leak, 0);

      csb1 = 1'b0; addr1 = 9'd0; csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd3;
      tick;
      chk("init0_d1_a", d1_a, 32'hDEADBEEF);
      chk("init0_v1_a", v1_a, 1);
      chk("dropped_wr_d0_a", d0_a, 32'hDEADBEEF);
      chk("init0_v1_b_lat", v1_b, 0);
      addr1 = 9'd511; csb0 = 1'b1;
      tick;
      chk("init511_d1_a", d1_a, 32'hDEADBEEF);
      chk("init0_d1_b", d1_b, 32'hDEADBEEF);
      chk("init0_v1_b", v1_b, 1);
      chk("dropped_wr_d0_b", d0_b, 32'hDEADBEEF);
      csb1 = 1'b1;
      tick;
      chk("idle_v1_a", v1_a, 0);
      chk("init511_v1_b", v1_b, 1);
      chk("init511_d1_b", d1_b, 32'hDEADBEEF);

      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd5; din0 = 32'hAAAAAAAA;
      tick;
      din0 = 32'h11223344; wmask0 = 4'b0101;
      tick;
      chk("wr_no_rvalid_a", v0_a, 0);
      chk("wr_hold_d0_a", d0_a, 32'hDEADBEEF);
      web0 = 1'b1;
      tick;
      chk("mask_v0_a", v0_a, 1);
      chk("mask_d0_a", d0_a, 32'hAA22AA44);
      chk("mask_v0_b_lat", v0_b, 0);
      csb0 = 1'b1;
      tick;
      chk("mask_pulse_a", v0_a, 0);
      chk("mask_hold_a", d0_a, 32'hAA22AA44);
      chk("mask_v0_b", v0_b, 1);
      chk("mask_d0_b", d0_b, 32'hAA22AA44);

      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd7; din0 = 32'h0;
      tick;
      din0 = 32'hCAFEF00D; csb1 = 1'b0; addr1 = 9'd7;
      tick;
      chk("byp_d1_a", d1_a, 32'hCAFEF00D);
      chk("byp_v1_a", v1_a, 1);
      csb0 = 1'b1;
      tick;
      chk("after_d1_a", d1_a, 32'hCAFEF00D);
      chk("nobyp_v1_b", v1_b, 1);
      chk("nobyp_d1_b", d1_b, 32'h0);
      csb0 = 1'b0; din0 = 32'h99999999; wmask0 = 4'b0011;
      tick;
      chk("byp_merge_a", d1_a, 32'hCAFE9999);
      chk("after_d1_b", d1_b, 32'hCAFEF00D);
      csb0 = 1'b1; csb1 = 1'b1;
      tick;
      chk("nobyp_merge_b", d1_b, 32'hCAFEF00D);
      chk("idle2_v1_a", v1_a, 0);
      csb1 = 1'b0;
      tick;
      chk("merge_rd_a", d1_a, 32'hCAFE9999);
      csb1 = 1'b1;
      tick;
      chk("merge_rd_b", d1_b, 32'hCAFE9999);

      for (int i = 0; i < 16; i++) begin
         csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'(i); din0 = 32'h1000 + i;
         tick;
      end
      csb0 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         csb1 = 1'b0; addr1 = 9'(i);
         tick;
         chk("stream_v1_a", v1_a, 1);
         chk("stream_d1_a", d1_a, 32'h1000 + i);
         if (i > 0) begin
            chk("stream_v1_b", v1_b, 1);
            chk("stream_d1_b", d1_b, 32'h1000 + i - 1);
         end
      end
      csb1 = 1'b1;
      tick;
      chk("stream_end_v1_a", v1_a, 0);
      chk("stream_last_v1_b", v1_b, 1);
      chk("stream_last_d1_b", d1_b, 32'h100F);
      tick;
      chk("stream_end_v1_b", v1_b, 0);

      csb0 = 1'b1; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd20; din0 = 32'hFFFFFFFF;
      tick;
      tick;
      chk("csb_wr_v0_a", v0_a, 0);
      chk("csb_wr_d0_a", d0_a, 32'hAA22AA44);
      chk("csb_wr_d0_b", d0_b, 32'hAA22AA44);
      csb0 = 1'b0; wmask0 = 4'h0;
      tick;
      tick;
      chk("nomask_v0_a", v0_a, 0);
      chk("nomask_v0_b", v0_b, 0);
      chk("nomask_d0_a", d0_a, 32'hAA22AA44);
      web0 = 1'b1;
      tick;
      chk("unchanged_d0_a", d0_a, 32'hDEADBEEF);
      csb0 = 1'b1;
      tick;
      chk("unchanged_d0_b", d0_b, 32'hDEADBEEF);
      chk("unchanged_v0_b", v0_b, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
